// File: rtl/mem_bus_arbiter_if.sv
// One valid/ready memory bus: a request channel (addr/wen/wdata/wmask)
// and a response channel (rdata). The master modport is the requesting side.
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic [ADDR_WIDTH-1:0]     addr;
    logic                      wen;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wmask;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_WIDTH-1:0]     rdata;

    modport master (
        output req_valid, addr, wen, wdata, wmask, rsp_ready,
        input  req_ready, rsp_valid, rdata
    );

    modport slave (
        input  req_valid, addr, wen, wdata, wmask, rsp_ready,
        output req_ready, rsp_valid, rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory slave between IFU (m0, read-only)
// and LSU (m1); exactly one transaction is in flight at a time.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mem_bus_arbiter_if.slave  m0,
    mem_bus_arbiter_if.slave  m1,
    mem_bus_arbiter_if.master s,
    output logic              grant_o,
    output logic              busy_o
);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, REQ, RSP, DLV} state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    owner_q, owner_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wen_q, wen_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wmask_q, wmask_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic any_req;
    logic winner;
    logic accept;
    logic owner_rsp_ready;

    // On contention the master that did not win last time goes first.
    always_comb begin
        any_req = m0.req_valid | m1.req_valid;
        if (m0.req_valid && m1.req_valid) begin
            winner = ~last_grant_q;
        end else begin
            winner = m1.req_valid;
        end
        accept          = (state_q == IDLE) && any_req;
        owner_rsp_ready = owner_q ? m1.rsp_ready : m0.rsp_ready;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)          state_d = REQ;
            REQ:     if (s.req_ready)     state_d = RSP;
            RSP:     if (s.rsp_valid)     state_d = DLV;
            DLV:     if (owner_rsp_ready) state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Request readies are gated by reset so nothing is accepted while held.
    always_comb begin
        m0.req_ready = rst_ni && (state_q == IDLE) && m0.req_valid && !winner;
        m1.req_ready = rst_ni && (state_q == IDLE) && m1.req_valid &&  winner;
        m0.rsp_valid = (state_q == DLV) && !owner_q;
        m1.rsp_valid = (state_q == DLV) &&  owner_q;
        m0.rdata     = rdata_q;
        m1.rdata     = rdata_q;
        s.req_valid  = (state_q == REQ);
        s.rsp_ready  = (state_q == RSP);
        s.addr       = addr_q;
        s.wen        = wen_q;
        s.wdata      = wdata_q;
        s.wmask      = wmask_q;
        grant_o      = owner_q;
        busy_o       = (state_q != IDLE);
    end

    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        rdata_d      = rdata_q;
        if (accept) begin
            last_grant_d = winner;
            owner_d      = winner;
            addr_d       = winner ? m1.addr : m0.addr;
            wen_d        = winner & m1.wen;
            wdata_d      = winner ? m1.wdata : '0;
            wmask_d      = winner ? m1.wmask : '0;
        end
        if ((state_q == RSP) && s.rsp_valid) begin
            rdata_d = s.rdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            rdata_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            rdata_q      <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single reads/writes, contention,
// backpressure and reset in the middle of a transaction.
module tb_mem_bus_arbiter;
    logic clk;
    logic rst_n;
    logic grant;
    logic busy;
    int   errors = 0;
    int   checks = 0;

    mem_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_bus ();
    mem_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_bus ();
    mem_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_bus ();

    mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .m0     (m0_bus.slave),
        .m1     (m1_bus.slave),
        .s      (s_bus.master),
        .grant_o(grant),
        .busy_o (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_bus.req_valid = 1'b1;  m0_bus.addr = '0; m0_bus.wen = 1'b0;
        m0_bus.wdata = '0; m0_bus.wmask = '0; m0_bus.rsp_ready = 1'b1;
        m1_bus.req_valid = 1'b1;  m1_bus.addr = '0; m1_bus.wen = 1'b0;
        m1_bus.wdata = '0; m1_bus.wmask = '0; m1_bus.rsp_ready = 1'b1;
        s_bus.req_ready = 1'b0;   s_bus.rsp_valid = 1'b0; s_bus.rdata = '0;
        s_bus.req_ready = 1'b0;

        // Reset state, with both masters already requesting.
        #3;
        chk("rst_m0_req_ready", 64'(m0_bus.req_ready), 64'd0);
        chk("rst_m1_req_ready", 64'(m1_bus.req_ready), 64'd0);
        chk("rst_busy",         64'(busy), 64'd0);
        chk("rst_grant",        64'(grant), 64'd0);
        chk("rst_s_req_valid",  64'(s_bus.req_valid), 64'd0);
        chk("rst_s_rsp_ready",  64'(s_bus.rsp_ready), 64'd0);
        chk("rst_s_addr",       64'(s_bus.addr), 64'd0);
        chk("rst_m0_rdata",     64'(m0_bus.rdata), 64'd0);
        m0_bus.req_valid = 1'b0;
        m1_bus.req_valid = 1'b0;
        cyc();
        rst_n = 1'b1;

        // Single IFU read through a zero-wait slave.
        cyc();
        m0_bus.req_valid = 1'b1; m0_bus.addr = 32'h8000_0000;
        s_bus.req_ready = 1'b1; s_bus.rsp_valid = 1'b1; s_bus.rdata = 32'h0000_0413;
        #1;
        chk("ifu_c0_m0_req_ready", 64'(m0_bus.req_ready), 64'd1);
        chk("ifu_c0_m1_req_ready", 64'(m1_bus.req_ready), 64'd0);
        chk("ifu_c0_busy",         64'(busy), 64'd0);
        cyc();
        m0_bus.req_valid = 1'b0;
        #1;
        chk("ifu_c1_s_req_valid", 64'(s_bus.req_valid), 64'd1);
        chk("ifu_c1_s_addr",      64'(s_bus.addr), 64'h8000_0000);
        chk("ifu_c1_s_wen",       64'(s_bus.wen), 64'd0);
        chk("ifu_c1_busy",        64'(busy), 64'd1);
        chk("ifu_c1_grant",       64'(grant), 64'd0);
        chk("ifu_c1_m1_rsp",      64'(m1_bus.rsp_valid), 64'd0);
        cyc(); #1;
        chk("ifu_c2_s_rsp_ready", 64'(s_bus.rsp_ready), 64'd1);
        chk("ifu_c2_m1_rsp",      64'(m1_bus.rsp_valid), 64'd0);
        cyc();
        m1_bus.req_valid = 1'b1; m1_bus.addr = 32'h0000_0bad;
        #1;
        chk("ifu_c3_m0_rsp_valid", 64'(m0_bus.rsp_valid), 64'd1);
        chk("ifu_c3_m0_rdata",     64'(m0_bus.rdata), 64'h0000_0413);
        chk("ifu_c3_m1_rsp",       64'(m1_bus.rsp_valid), 64'd0);
        chk("ifu_c3_m1_no_accept", 64'(m1_bus.req_ready), 64'd0);
        m1_bus.req_valid = 1'b0;
        cyc(); #1;
        chk("ifu_c4_busy",   64'(busy), 64'd0);
        chk("ifu_c4_m1_rsp", 64'(m1_bus.rsp_valid), 64'd0);

        // LSU write.
        m1_bus.req_valid = 1'b1; m1_bus.addr = 32'h8000_0100; m1_bus.wen = 1'b1;
        m1_bus.wdata = 32'hDEAD_BEEF; m1_bus.wmask = 4'h3; s_bus.rdata = 32'h1234_5678;
        #1;
        chk("lsu_c0_m1_req_ready", 64'(m1_bus.req_ready), 64'd1);
        chk("lsu_c0_m0_req_ready", 64'(m0_bus.req_ready), 64'd0);
        cyc();
        m1_bus.req_valid = 1'b0;
        #1;
        chk("lsu_c1_s_addr",  64'(s_bus.addr), 64'h8000_0100);
        chk("lsu_c1_s_wen",   64'(s_bus.wen), 64'd1);
        chk("lsu_c1_s_wdata", 64'(s_bus.wdata), 64'hDEAD_BEEF);
        chk("lsu_c1_s_wmask", 64'(s_bus.wmask), 64'h3);
        chk("lsu_c1_grant",   64'(grant), 64'd1);
        cyc(); cyc(); #1;
        chk("lsu_c3_m1_rsp_valid", 64'(m1_bus.rsp_valid), 64'd1);
        chk("lsu_c3_m0_rsp_valid", 64'(m0_bus.rsp_valid), 64'd0);
        m1_bus.wen = 1'b0; m1_bus.wdata = '0; m1_bus.wmask = '0;

        // Contention right after a fresh reset: IFU first, then alternate.
        #1;
        rst_n = 1'b0;
        #2;
        chk("rst2_busy", 64'(busy), 64'd0);
        cyc();
        rst_n = 1'b1;
        m0_bus.req_valid = 1'b1; m0_bus.addr = 32'h0000_0100;
        m1_bus.req_valid = 1'b1; m1_bus.addr = 32'h0000_0200;
        for (int t = 0; t < 4; t++) begin
            #1;
            chk("cont_m0_req_ready", 64'(m0_bus.req_ready), 64'((t % 2) == 0));
            chk("cont_m1_req_ready", 64'(m1_bus.req_ready), 64'((t % 2) == 1));
            cyc(); #1;
            chk("cont_grant",  64'(grant), 64'(t % 2));
            chk("cont_s_addr", 64'(s_bus.addr), ((t % 2) == 0) ? 64'h100 : 64'h200);
            chk("cont_m0_req_ready_busy", 64'(m0_bus.req_ready), 64'd0);
            chk("cont_m1_req_ready_busy", 64'(m1_bus.req_ready), 64'd0);
            cyc(); cyc(); cyc();
        end
        m0_bus.req_valid = 1'b0;
        m1_bus.req_valid = 1'b0;
        cyc();

        // Backpressure: slave request stall, then master response stall.
        m1_bus.req_valid = 1'b1; m1_bus.addr = 32'h8000_0040;
        s_bus.req_ready = 1'b0; s_bus.rdata = 32'hCAFE_F00D;
        #1;
        chk("bp_c0_m1_req_ready", 64'(m1_bus.req_ready), 64'd1);
        cyc();
        m1_bus.req_valid = 1'b0; m1_bus.addr = 32'hFFFF_FFFF;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk("bp_stall_s_req_valid", 64'(s_bus.req_valid), 64'd1);
            chk("bp_stall_s_addr",      64'(s_bus.addr), 64'h8000_0040);
            chk("bp_stall_s_rsp_ready", 64'(s_bus.rsp_ready), 64'd0);
            cyc();
        end
        s_bus.req_ready = 1'b1;
        m1_bus.rsp_ready = 1'b0;
        #1;
        chk("bp_c4_s_req_valid", 64'(s_bus.req_valid), 64'd1);
        cyc(); #1;
        chk("bp_c5_s_rsp_ready", 64'(s_bus.rsp_ready), 64'd1);
        cyc(); #1;
        chk("bp_c6_m1_rsp_valid", 64'(m1_bus.rsp_valid), 64'd1);
        chk("bp_c6_m1_rdata",     64'(m1_bus.rdata), 64'hCAFE_F00D);
        s_bus.rdata = 32'h0;
        cyc(); #1;
        chk("bp_c7_m1_rsp_valid", 64'(m1_bus.rsp_valid), 64'd1);
        chk("bp_c7_m1_rdata",     64'(m1_bus.rdata), 64'hCAFE_F00D);
        m1_bus.rsp_ready = 1'b1;
        cyc(); #1;
        chk("bp_c8_busy", 64'(busy), 64'd0);
        chk("bp_c8_m1_rsp_valid", 64'(m1_bus.rsp_valid), 64'd0);

        // Reset while waiting in RSP.
        s_bus.rsp_valid = 1'b0;
        m0_bus.req_valid = 1'b1; m0_bus.addr = 32'h0000_0500;
        cyc();
        m0_bus.req_valid = 1'b0;
        cyc(); #1;
        chk("rr_rsp_s_rsp_ready", 64'(s_bus.rsp_ready), 64'd1);
        m0_bus.req_valid = 1'b1; m1_bus.req_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rr_busy",         64'(busy), 64'd0);
        chk("rr_s_rsp_ready",  64'(s_bus.rsp_ready), 64'd0);
        chk("rr_s_req_valid",  64'(s_bus.req_valid), 64'd0);
        chk("rr_m0_req_ready", 64'(m0_bus.req_ready), 64'd0);
        chk("rr_m1_req_ready", 64'(m1_bus.req_ready), 64'd0);
        chk("rr_s_addr",       64'(s_bus.addr), 64'd0);
        s_bus.rsp_valid = 1'b1; s_bus.rdata = 32'h5555_AAAA;
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rr_post_m0_req_ready", 64'(m0_bus.req_ready), 64'd1);
        chk("rr_post_m1_req_ready", 64'(m1_bus.req_ready), 64'd0);
        chk("rr_post_s_rsp_ready",  64'(s_bus.rsp_ready), 64'd0);
        chk("rr_post_m0_rsp_valid", 64'(m0_bus.rsp_valid), 64'd0);
        cyc();
        m0_bus.req_valid = 1'b0; m1_bus.req_valid = 1'b0;
        #1;
        chk("rr_req_grant",       64'(grant), 64'd0);
        chk("rr_req_s_rsp_ready", 64'(s_bus.rsp_ready), 64'd0);
        chk("rr_req_m0_rsp",      64'(m0_bus.rsp_valid), 64'd0);
        chk("rr_req_m1_rsp",      64'(m1_bus.rsp_valid), 64'd0);
        chk("rr_req_s_addr",      64'(s_bus.addr), 64'h0000_0500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master, one-slave arbiter that shares the single memory port between the instruction fetch unit (master 0, read-only) and the load/store unit (master 1, read/write). It sits between the IFU/LSU memory interfaces and the memory/bus slave. It serialises one outstanding transaction at a time with round-robin priority. All channels use valid/ready handshakes, consistent with the inter-stage buses.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
---
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req_valid / m0_req_ready  in / out  1  IFU request handshake
- m0_addr  in  ADDR_WIDTH  IFU fetch address
- m0_rsp_valid / m0_rsp_ready  out / in  1  IFU response handshake
- m0_rdata  out  DATA_WIDTH  fetched word
- m1_req_valid / m1_req_ready  in / out  1  LSU request handshake
- m1_addr  in  ADDR_WIDTH  LSU address
- m1_wen  in  1  1 = write, 0 = read
- m1_wdata  in  DATA_WIDTH  store data
- m1_wmask  in  DATA_WIDTH/8  byte strobes
- m1_rsp_valid / m1_rsp_ready  out / in  1  LSU response handshake; returned for writes too
- m1_rdata  out  DATA_WIDTH  load data; don't-care for writes
- s_req_valid / s_req_ready  out / in  1  slave request handshake
- s_addr, s_wen, s_wdata, s_wmask  out  ADDR_WIDTH, 1, DATA_WIDTH, DATA_WIDTH/8  latched request fields
- s_rsp_valid / s_rsp_ready  in / out  1  slave response handshake
- s_rdata  in  DATA_WIDTH  slave read data
- grant  out  1  owner of the current or last transaction (0 = IFU, 1 = LSU)
- busy  out  1  state != IDLE

## Operation
- FSM: IDLE -> REQ -> RSP -> DLV -> IDLE. Exactly one transaction is in flight at a time.
- **IDLE**
  - Winner selection:
    - Only one master is requesting: that master wins.
    - Both are requesting: the master other than last_grant wins.
  - The winner's mX_req_ready = 1 combinationally. The loser's req_ready = 0.
  - On the handshake:
    - Latch addr, wen, wdata, and wmask. Master 0 forces wen = 0 and wmask = 0.
    - Set owner = winner and last_grant = winner.
    - Go to REQ.
- **REQ**
  - s_req_valid = 1, with the latched fields driven on s_*.
  - On s_req_ready, go to RSP.
  - All mX_req_ready = 0.
- **RSP**
  - s_rsp_ready = 1.
  - On s_rsp_valid, latch s_rdata into the rdata register and go to DLV.
- **DLV**
  - The owner's mX_rsp_valid = 1, and mX_rdata = the rdata register.
  - The non-owner's rsp_valid = 0.
  - On the owner's rsp_ready, go to IDLE.
- mX_rdata is driven from the rdata register at all times. Its value is only meaningful while rsp_valid = 1.
- Request fields on s_* are stable from REQ entry until the s_req handshake.
- Master inputs are not sampled outside IDLE.

## Timing
- **Reset** (reset = 0, asynchronous):
  - State: state = IDLE, last_grant = 1, owner = 0, grant = 0.
  - Latched registers: all latched fields and rdata = 0.
  - Outputs: every valid/ready output = 0 and busy = 0.
  - The IDLE req_ready outputs are gated by reset, so they stay 0 while reset is low.
- After reset release, the first simultaneous request goes to IFU.
- **Minimum latency**, with a zero-wait slave and masters always ready:
  - Cycle 0: IDLE accept.
  - Cycle 1: REQ handshake.
  - Cycle 2: RSP handshake.
  - Cycle 3: DLV, rsp delivered.
  - Cycle 4: IDLE, next request can be accepted.
  - One transaction per 4 cycles at best.
- **Wait states:** each slave wait cycle in REQ or RSP, and each master stall in DLV, adds one cycle.
- **Back-to-back requests:**
  - Both masters continuously requesting alternate IFU, LSU, IFU, and so on.
  - A single continuous requester is granted every transaction.
- **Simultaneous events:** a request arriving in the same cycle DLV completes is not accepted until the next cycle (IDLE).
- **Reset during a transaction:**
  - The transaction is abandoned and no response is delivered.
  - A slave response that arrives later while in IDLE/REQ is not accepted (s_rsp_ready = 0). Slave-side recovery is the slave's responsibility.
- grant changes only on an IDLE accept. busy goes high in the cycle after the accept.

## Test plan
- **Single IFU read:** m0 requests 0x8000_0000; slave returns 0x0000_0413 with zero wait.
  - m0_req_ready = 1 at cycle 0.
  - s_addr = 0x8000_0000 and s_wen = 0 at cycle 1.
  - m0_rsp_valid = 1 with m0_rdata = 0x0000_0413 at cycle 3.
  - m1_rsp_valid stays 0 throughout.
- **LSU write:** m1 writes 0xDEAD_BEEF to 0x8000_0100 with mask 0x3.
  - s_wen = 1, s_wdata = 0xDEAD_BEEF, s_wmask = 0x3.
  - m1_rsp_valid is asserted after the slave responds.
- **Contention:** both masters hold valid for 4 transactions after reset.
  - Grant order is 0, 1, 0, 1.
  - The loser's req_ready stays 0 until its turn.
- **Backpressure:**
  - s_req_ready is held low for 3 cycles: s_* fields are stable, and the response arrives at cycle 6.
  - m1_rsp_ready is held low for 2 cycles in DLV: m1_rsp_valid and m1_rdata are held stable.
- **Reset mid-RSP:** assert reset while in RSP.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, no response is delivered, and the next simultaneous request is granted to IFU.
